hs_rr_arb: RTL and testbench
============================

// Module: hs_rr_arb
// PURPOSE
//  N-way round-robin arbiter merging N valid/ready requester channels onto one shared
//  valid/ready output channel. Packet-aware: once a requester wins, the grant is held until its
//  beat with last_in=1 is accepted. Output is registered through a 2-entry skid stage, so no
//  combinational path runs from ready_out to ready_in. Sits in front of shared downstream buffers.
// PARAMETERS
//  N_REQ    4   number of requester channels (>=2)
//  DATA_WD  32  payload width per channel
//  ID_WD    $clog2(N_REQ)  width of source id
// PORTS
//  clk        in   1              clock; all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  valid_in   in   N_REQ          per-requester valid
//  data_in    in   N_REQ*DATA_WD  packed payloads; requester i at [i*DATA_WD +: DATA_WD]
//  last_in    in   N_REQ          per-requester end-of-packet flag
//  ready_in   out  N_REQ          per-requester ready; at most one bit set per cycle
//  valid_out  out  1              output valid
//  data_out   out  DATA_WD        output payload
//  last_out   out  1              output end-of-packet
//  src_id_out out  ID_WD          index of the requester that produced the output beat
//  ready_out  in   1              downstream ready
// BEHAVIOUR
//  Reset (rst=1 at posedge): valid_out=0, skid empty, state=IDLE, rr_ptr=0, lock_id=0.
//   Other outputs are don't-care while valid_out=0. Reset mid-packet discards the lock and any
//   buffered beats. No recovery of in-flight data.
//  Fire: fire_in[i]=valid_in[i]&ready_in[i]; fire_out=valid_out&ready_out.
//  Requester rule: valid_in/data_in/last_in held stable until fire. The block does not check it.
//  Grant (combinational):
//   IDLE: gnt = first i with valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    If no request, gnt is none.
//   LOCK: gnt = lock_id, whether or not valid_in[lock_id] is set. No other requester is served.
//  ready_in[i] = (i==gnt) & skid_ready. skid_ready=1 when the skid holds <2 entries.
//   ready_in may depend on valid_in; valid_in must never depend on ready_in.
//  FSM (2 states):
//   IDLE->LOCK on fire_in with last_in[gnt]=0; lock_id<=gnt.
//   LOCK->IDLE on fire_in with last_in[lock_id]=1.
//   IDLE->IDLE on fire_in with last=1 (single-beat packet).
//  rr_ptr <= (gnt+1) mod N_REQ on every fire_in with last=1 (wrap N_REQ-1 -> 0).
//   rr_ptr holds otherwise, so the winner becomes lowest priority after its packet completes.
//  Skid stage: a 2-entry FIFO of {data, last, id}.
//   Latency: 1 cycle from fire_in to valid_out.
//   Throughput: 1 beat/cycle sustained.
//   Full (2 entries): skid_ready=0, so all ready_in=0.
//   Simultaneous push+pop when full: not possible, because ready is registered.
//   Simultaneous push+pop with 1 entry: occupancy stays 1.
//   Order preserved.
//  valid_out/data_out/last_out/src_id_out come from the head entry, are driven from flops, and
//   are held stable while valid_out & !ready_out.
//  No interleaving: beats of different packets never mix on the output.
// STRUCTURE
//  hs_arb_pkg:
//   - typedef enum {IDLE, LOCK} arb_state_t;
//   - function rr_pick(req, ptr) returning the index plus a found bit.
//  Sub-module hs_skid_buf #(W) implements the 2-entry registered buffer, clk/rst as above.
//   It is reused elsewhere.
//  Top level: grant logic, FSM, rr_ptr, input mux, one hs_skid_buf instance.
// TESTING
//  1. Reset release, no requests -> valid_out=0, all ready_in=0 for 10 cycles.
//   Hold rst mid-packet -> lock cleared.
//  2. N_REQ=4, all valid, last=1, ready_out=1 -> src_id_out sequence 0,1,2,3,0,...
//   1 beat/cycle after the first-cycle latency.
//  3. Req1 sends a 3-beat packet (last on beat 3) while req0/2 also valid.
//   -> 3 consecutive beats with id=1, then id=2, then id=3 if valid, else id=0.
//  4. ready_out=0 for 5 cycles with a stream active.
//   -> exactly 2 beats accepted, ready_in=0 after that, valid_out/data_out stable.
//   Then ready_out=1 -> no loss or duplication.
//  5. Locked req2 drops valid_in mid-packet for 3 cycles while req0 is valid.
//   -> ready_in[0]=0 throughout, grant resumes on req2.
//  6. Random valid/last/ready for 10k cycles.
//   -> scoreboard shows per-source order preserved, packets contiguous.
//   -> no source waits more than N_REQ-1 packets.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared types and the round-robin pick function for the packet-aware arbiter.
package hs_arb_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int MAX_REQ   = 32;
  localparam int MAX_ID_WD = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_ID_WD-1:0] idx;
  } pick_t;

  // First set bit at or above ptr wins; otherwise wrap to the lowest set bit.
  // Callers zero-extend req, so unused upper bits never win.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [MAX_ID_WD-1:0] ptr);
    pick_t lo;
    pick_t hi;
    lo = '0;
    hi = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo.found = 1'b1;
        lo.idx   = MAX_ID_WD'(i);
        if (i >= int'(ptr)) begin
          hi.found = 1'b1;
          hi.idx   = MAX_ID_WD'(i);
        end
      end
    end
    return hi.found ? hi : lo;
  endfunction

endpackage

// File: rtl/hs_skid_buf.sv
// 2-entry registered FIFO: 1-cycle push-to-pop latency, 1 beat/cycle sustained.
// push_ready comes only from a flop, so it never depends on pop_ready in the same cycle.
module hs_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         head_full;
  logic         tail_full;
  logic         push;
  logic         pop;

  assign push_ready = !tail_full;
  assign pop_valid  = head_full;
  assign pop_data   = head;
  assign push       = push_valid & push_ready;
  assign pop        = head_full & pop_ready;

  // tail is only ever occupied behind a full head, and a push never lands while tail is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_full <= 1'b0;
      tail_full <= 1'b0;
    end else if (pop) begin
      if (tail_full) begin
        head      <= tail;
        tail_full <= 1'b0;
      end else if (push) begin
        head <= push_data;
      end else begin
        head_full <= 1'b0;
      end
    end else if (push) begin
      if (!head_full) begin
        head      <= push_data;
        head_full <= 1'b1;
      end else begin
        tail      <= push_data;
        tail_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_rr_arb.sv
// Packet-aware round-robin merge of N_REQ valid/ready channels; 1-cycle latency via skid stage.
// A winner keeps the grant until its last beat is accepted; ready_in drops when the skid is full.
module hs_rr_arb #(
  parameter int N_REQ   = 4,
  parameter int DATA_WD = 32,
  parameter int ID_WD   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         valid_in,
  input  logic [N_REQ*DATA_WD-1:0] data_in,
  input  logic [N_REQ-1:0]         last_in,
  output logic [N_REQ-1:0]         ready_in,
  output logic                     valid_out,
  output logic [DATA_WD-1:0]       data_out,
  output logic                     last_out,
  output logic [ID_WD-1:0]         src_id_out,
  input  logic                     ready_out
);

  import hs_arb_pkg::*;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic               last;
    logic [ID_WD-1:0]   id;
  } beat_t;

  localparam int BEAT_WD = $bits(beat_t);

  arb_state_t       state;
  logic [ID_WD-1:0] rr_ptr;
  logic [ID_WD-1:0] lock_id;
  logic [ID_WD-1:0] gnt;
  logic             gnt_any;
  logic             push_valid;
  logic             skid_ready;
  logic             fire;
  pick_t            pick;
  beat_t            in_beat;
  beat_t            out_beat;

  always_comb begin
    pick = rr_pick(MAX_REQ'(valid_in), MAX_ID_WD'(rr_ptr));
    if (state == LOCK) begin
      gnt     = lock_id;
      gnt_any = 1'b1;
    end else begin
      gnt     = pick.idx[ID_WD-1:0];
      gnt_any = pick.found;
    end
  end

  // While locked, ready follows lock_id even if that requester has paused its valid.
  always_comb begin
    ready_in = '0;
    if (gnt_any && skid_ready) ready_in[gnt] = 1'b1;
  end

  assign push_valid = gnt_any & valid_in[gnt];
  assign fire       = push_valid & skid_ready;

  always_comb begin
    in_beat      = '0;
    in_beat.data = data_in[gnt*DATA_WD +: DATA_WD];
    in_beat.last = last_in[gnt];
    in_beat.id   = gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (fire) begin
      if (in_beat.last) begin
        state  <= IDLE;
        rr_ptr <= (gnt == ID_WD'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      end else begin
        state   <= LOCK;
        lock_id <= gnt;
      end
    end
  end

  hs_skid_buf #(.W(BEAT_WD)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (skid_ready),
    .push_data  (in_beat),
    .pop_valid  (valid_out),
    .pop_ready  (ready_out),
    .pop_data   (out_beat)
  );

  assign data_out   = out_beat.data;
  assign last_out   = out_beat.last;
  assign src_id_out = out_beat.id;

endmodule

// File: tb/tb_hs_rr_arb.sv
// Directed and random checks of hs_rr_arb against a grant model and an in-order beat scoreboard.
module tb_hs_rr_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]    last_in = '0;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic            last_out;
  logic [IDW-1:0]  src_id_out;
  logic            ready_out = 1'b0;

  hs_rr_arb #(.N_REQ(N), .DATA_WD(DW), .ID_WD(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .last_in    (last_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .last_out   (last_out),
    .src_id_out (src_id_out),
    .ready_out  (ready_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [DW:0]       sbeat_t;
  typedef logic [DW+IDW:0]   obeat_t;
  sbeat_t         src_q [N][$];
  obeat_t         sb [$];
  logic [IDW-1:0] out_log [$];

  logic [N-1:0] fire_vec = '0;
  logic [N-1:0] gate     = '1;
  logic         rst_req  = 1'b1;
  logic         ro_req   = 1'b0;
  int           seq      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change only here, 1ns after the edge; returns at the following negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    rst       = rst_req;
    ready_out = ro_req;
    for (int i = 0; i < N; i++) begin
      if (fire_vec[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (gate[i] && src_q[i].size() > 0) begin
        valid_in[i]           = 1'b1;
        data_in[i*DW +: DW]   = src_q[i][0][DW:1];
        last_in[i]            = src_q[i][0][0];
      end else begin
        valid_in[i]           = 1'b0;
        data_in[i*DW +: DW]   = '0;
        last_in[i]            = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic load(input int src, input int len, input int tag);
    for (int b = 0; b < len; b++) begin
      src_q[src].push_back({8'(src), 8'(tag), 16'(seq), (b == len - 1)});
      seq++;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst_req = 1'b1;
    cyc();
    cyc();
    rst_req = 1'b0;
    cyc();
  endtask

  task automatic drain();
    bit done;
    done   = 1'b0;
    ro_req = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      cyc();
      done = (sb.size() == 0) && !valid_out;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    chk("drain_done", done, 1'b1);
  endtask

  task automatic chk_log(input string tag, input int n, input logic [IDW-1:0] exp [5]);
    chk({tag, "_count"}, out_log.size(), n);
    for (int k = 0; k < n; k++)
      chk(tag, (k < out_log.size()) ? 64'(out_log[k]) : 64'hDEAD, exp[k]);
  endtask

  // Monitor: grant model, scoreboard, hold stability, contiguity and fairness.
  logic           m_lock;
  int             m_id;
  int             m_ptr;
  int             wait_pk [N];
  logic [N-1:0]   exp_rdy;
  bit             in_pkt;
  logic [IDW-1:0] pkt_id;
  bit             have_prev;
  logic [DW+3:0]  prev;
  obeat_t         e;

  always @(negedge clk) begin
    fire_vec = valid_in & ready_in;
    if (rst) begin
      sb.delete();
      m_lock    = 1'b0;
      m_id      = 0;
      m_ptr     = 0;
      in_pkt    = 1'b0;
      have_prev = 1'b0;
      for (int i = 0; i < N; i++) wait_pk[i] = 0;
    end else begin
      bit found;
      int g;
      found = 1'b0;
      g     = 0;
      if (m_lock) begin
        found = 1'b1;
        g     = m_id;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!found && valid_in[(m_ptr + k) % N]) begin
            found = 1'b1;
            g     = (m_ptr + k) % N;
          end
        end
      end
      exp_rdy = '0;
      if (found && sb.size() < 2) exp_rdy[g] = 1'b1;
      chk("ready_in", ready_in, exp_rdy);
      chk("valid_out", valid_out, sb.size() != 0);
      if (have_prev) chk("hold_stable", {valid_out, last_out, src_id_out, data_out}, prev);

      if (valid_out && ready_out) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", data_out, e[DW+IDW:IDW+1]);
          chk("out_last", last_out, e[IDW]);
          chk("out_id", src_id_out, e[IDW-1:0]);
        end
        if (in_pkt) chk("contiguous", src_id_out, pkt_id);
        in_pkt = !last_out;
        pkt_id = src_id_out;
        out_log.push_back(src_id_out);
      end
      have_prev = valid_out && !ready_out;
      prev      = {valid_out, last_out, src_id_out, data_out};

      for (int i = 0; i < N; i++) begin
        if (fire_vec[i]) begin
          chk("fair_wait", wait_pk[i] <= N - 1, 1'b1);
          wait_pk[i] = 0;
          sb.push_back({data_in[i*DW +: DW], last_in[i], IDW'(i)});
          if (last_in[i]) begin
            m_lock = 1'b0;
            m_ptr  = (i + 1) % N;
            for (int j = 0; j < N; j++) if (j != i && valid_in[j]) wait_pk[j]++;
          end else begin
            m_lock = 1'b1;
            m_id   = i;
          end
        end
      end
    end
  end

  initial begin
    logic [IDW-1:0] exp_ids [5];
    logic [DW-1:0]  d0;

    // Reset and idle
    do_reset();
    chk("rst_valid_out", valid_out, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_valid_out", valid_out, 1'b0);
      chk("idle_ready_in", ready_in, 4'b0000);
    end

    // Reset mid-packet drops the lock and rewinds rr_ptr
    ro_req = 1'b1;
    load(3, 4, 1);
    cyc();
    cyc();
    chk("locked_src3", ready_in, 4'b1000);
    do_reset();
    chk("rst_mid_valid_out", valid_out, 1'b0);
    load(0, 1, 1);
    load(3, 1, 1);
    cyc();
    chk("post_rst_grant", ready_in, 4'b0001);
    drain();

    // All requesters, single-beat packets: 0,1,2,3,0,... at one beat per cycle
    for (int i = 0; i < N; i++) load(i, 1, 2);
    for (int i = 0; i < N; i++) load(i, 1, 2);
    for (int i = 0; i < N; i++) load(i, 1, 2);
    cyc();
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("rr_valid", valid_out, 1'b1);
      chk("rr_order", src_id_out, k % N);
    end
    drain();

    // Multi-beat packet from req1 is not interleaved
    load(0, 1, 3);
    drain();
    out_log.delete();
    load(1, 3, 3);
    load(0, 1, 3);
    load(2, 1, 3);
    drain();
    exp_ids = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    chk_log("pkt_order", 5, exp_ids);

    // Downstream stall: exactly two beats absorbed, output held
    out_log.delete();
    ro_req = 1'b0;
    load(0, 6, 4);
    d0 = src_q[0][0][DW:1];
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_ready_in", ready_in, 4'b0000);
      chk("stall_valid_out", valid_out, 1'b1);
      chk("stall_data_out", data_out, d0);
    end
    chk("stall_accepted", src_q[0].size(), 4);
    drain();
    chk("stall_out_count", out_log.size(), 6);

    // Locked req2 pauses; req0 must not be served in the gap
    out_log.delete();
    load(2, 3, 5);
    cyc();
    chk("lock2_first", ready_in, 4'b0100);
    gate[2] = 1'b0;
    load(0, 1, 5);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("lock2_pause", ready_in, 4'b0100);
    end
    gate[2] = 1'b1;
    drain();
    exp_ids = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    chk_log("lock2_order", 4, exp_ids);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() == 0 && $urandom_range(3) == 0) load(i, $urandom_range(1, 4), 6);
      ro_req = ($urandom_range(3) != 0);
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
